// File: rtl/gen_bus_write_buffer.sv
`timescale 1ns/1ps
// Posted-write buffer between the memory controller generic bus and a bridge.
// Writes complete upstream on enqueue; reads wait until the FIFO has drained.
module gen_bus_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] up_addr,
  input  logic [31:0] up_wdata,
  input  logic [3:0]  up_byte_en,
  input  logic        up_ren,
  input  logic        up_wen,
  output logic        up_busy,
  output logic [31:0] up_rdata,
  output logic [31:0] dn_addr,
  output logic [31:0] dn_wdata,
  output logic [3:0]  dn_byte_en,
  output logic        dn_ren,
  output logic        dn_wen,
  input  logic        dn_busy,
  input  logic [31:0] dn_rdata,
  input  logic        flush,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, READ} state_t;

  state_t        state, state_n;
  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    be_mem   [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic          has, push, pop;

  assign has   = (count != '0);
  assign empty = ~has;

  // Reset gating keeps up_busy high while nRST is asserted.
  assign push = nRST && (state == IDLE) && up_wen && !up_ren
             && (count < FULL) && !flush;
  assign pop  = (state == IDLE) && has && !dn_busy;

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[tail] <= up_addr;
      data_mem[tail] <= up_wdata;
      be_mem[tail]   <= up_byte_en;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      if (push)
        tail <= tail + AW'(1);
      if (pop)
        head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    up_busy    = 1'b1;
    up_rdata   = '0;
    dn_addr    = '0;
    dn_wdata   = '0;
    dn_byte_en = '0;
    dn_ren     = 1'b0;
    dn_wen     = 1'b0;
    unique case (state)
      IDLE: begin
        if (has) begin
          dn_wen     = 1'b1;
          dn_addr    = addr_mem[head];
          dn_wdata   = data_mem[head];
          dn_byte_en = be_mem[head];
        end else if (up_ren) begin
          state_n = READ;
        end
        if (push)
          up_busy = 1'b0;
      end
      READ: begin
        dn_ren     = 1'b1;
        dn_addr    = up_addr;
        dn_byte_en = up_byte_en;
        if (!dn_busy) begin
          up_busy  = 1'b0;
          up_rdata = dn_rdata;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gen_bus_write_buffer.sv
`timescale 1ns/1ps
// Bench for gen_bus_write_buffer: queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gen_bus_write_buffer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic [31:0] up_addr = '0;
  logic [31:0] up_wdata = '0;
  logic [3:0]  up_byte_en = '0;
  logic        up_ren = 1'b0;
  logic        up_wen = 1'b0;
  logic        up_busy;
  logic [31:0] up_rdata;
  logic [31:0] dn_addr;
  logic [31:0] dn_wdata;
  logic [3:0]  dn_byte_en;
  logic        dn_ren;
  logic        dn_wen;
  logic        dn_busy = 1'b1;
  logic [31:0] dn_rdata = '0;
  logic        flush = 1'b0;
  logic        empty;

  always #5 CLK = ~CLK;

  gen_bus_write_buffer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .up_addr(up_addr), .up_wdata(up_wdata), .up_byte_en(up_byte_en),
    .up_ren(up_ren), .up_wen(up_wen), .up_busy(up_busy),
    .up_rdata(up_rdata),
    .dn_addr(dn_addr), .dn_wdata(dn_wdata), .dn_byte_en(dn_byte_en),
    .dn_ren(dn_ren), .dn_wen(dn_wen), .dn_busy(dn_busy),
    .dn_rdata(dn_rdata),
    .flush(flush), .empty(empty)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending writes in order, plus whether a read owns the bus.
  logic [31:0] qa[$];
  logic [31:0] qd[$];
  logic [3:0]  qb[$];
  bit          rd = 1'b0;
  bit          m_push, m_pop, m_go, m_end;
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  always @(negedge CLK) begin : cmp
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    logic        e_ren, e_wen, e_busy;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_be = '0;
    e_ren = 1'b0; e_wen = 1'b0; e_busy = 1'b1;
    m_push = 1'b0; m_pop = 1'b0; m_go = 1'b0; m_end = 1'b0;
    if (!nRST) begin
      qa.delete(); qd.delete(); qb.delete();
      rd = 1'b0;
    end else if (rd) begin
      e_ren  = 1'b1;
      e_addr = up_addr;
      e_be   = up_byte_en;
      if (!dn_busy) begin
        e_busy  = 1'b0;
        e_rdata = dn_rdata;
        m_end   = 1'b1;
      end
    end else begin
      if (qa.size() > 0) begin
        e_wen   = 1'b1;
        e_addr  = qa[0];
        e_wdata = qd[0];
        e_be    = qb[0];
        m_pop   = !dn_busy;
      end else if (up_ren) begin
        m_go = 1'b1;
      end
      if (up_wen && !up_ren && !flush && qa.size() < DEPTH) begin
        m_push = 1'b1;
        e_busy = 1'b0;
      end
    end
    chk("m_up_busy", up_busy, e_busy);
    chk("m_up_rdata", up_rdata, e_rdata);
    chk("m_dn_addr", dn_addr, e_addr);
    chk("m_dn_wdata", dn_wdata, e_wdata);
    chk("m_dn_be", dn_byte_en, e_be);
    chk("m_dn_ren", dn_ren, e_ren);
    chk("m_dn_wen", dn_wen, e_wen);
    chk("m_empty", empty, (qa.size() == 0));
    if (m_pop) begin
      log_a.push_back(dn_addr);
      log_d.push_back(dn_wdata);
    end
  end

  always @(posedge CLK) begin
    if (nRST) begin
      if (m_pop) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
        void'(qb.pop_front());
      end
      if (m_push) begin
        qa.push_back(up_addr);
        qd.push_back(up_wdata);
        qb.push_back(up_byte_en);
      end
      if (m_go)  rd = 1'b1;
      if (m_end) rd = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be, output int waited);
    up_addr = a; up_wdata = d; up_byte_en = be; up_wen = 1'b1;
    waited = 0;
    @(negedge CLK);
    while (up_busy !== 1'b0 && waited < 50) begin
      waited++;
      @(negedge CLK);
    end
    chk("wr_done", up_busy, 1'b0);
    @(posedge CLK);
    #1;
    up_wen = 1'b0;
  endtask

  task automatic drain();
    int k;
    dn_busy = 1'b0;
    k = 0;
    @(negedge CLK);
    while (empty !== 1'b1 && k < 50) begin
      k++;
      @(negedge CLK);
    end
    chk("drain_empty", empty, 1'b1);
    @(posedge CLK);
    #1;
    dn_busy = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    int k;
    #1 nRST = 1'b0;
    cyc(2);
    chk("rst_busy", up_busy, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_dnwen", dn_wen, 1'b0);
    nRST = 1'b1;
    cyc(2);
    chk("idle_busy", up_busy, 1'b1);
    chk("idle_dnren", dn_ren, 1'b0);
    chk("idle_dnwen", dn_wen, 1'b0);
    chk("idle_empty", empty, 1'b1);

    // single posted write
    wr(32'h100, 32'hDEADBEEF, 4'hF, w);
    chk("s1_lat", w, 0);
    chk("s1_dnwen", dn_wen, 1'b1);
    chk("s1_dnaddr", dn_addr, 32'h100);
    chk("s1_dnwdata", dn_wdata, 32'hDEADBEEF);
    dn_busy = 1'b0;
    cyc(1);
    dn_busy = 1'b1;
    chk("s1_empty", empty, 1'b1);

    // fill to full, fifth write stalls until a pop registers
    log_a.delete(); log_d.delete();
    for (int i = 0; i < 4; i++) begin
      wr(32'(i * 4), 32'hA000 + 32'(i), 4'hF, w);
      chk("s2_lat", w, 0);
    end
    up_addr = 32'h10; up_wdata = 32'hA004; up_wen = 1'b1;
    @(negedge CLK);
    chk("s2_stall", up_busy, 1'b1);
    @(posedge CLK); #1;
    dn_busy = 1'b0;
    @(negedge CLK);
    chk("s2_samecyc", up_busy, 1'b1);
    @(posedge CLK); #1;
    dn_busy = 1'b1;
    @(negedge CLK);
    chk("s2_free", up_busy, 1'b0);
    @(posedge CLK); #1;
    up_wen = 1'b0;
    drain();
    chk("s2_cnt", log_a.size(), 5);
    for (int i = 0; i < 5 && i < log_a.size(); i++) begin
      chk("s2_order", log_a[i], 32'(i * 4));
      chk("s2_data", log_d[i], 32'hA000 + 32'(i));
    end

    // read waits behind a pending write
    wr(32'h200, 32'h11223344, 4'hF, w);
    up_addr = 32'h200; up_byte_en = 4'h3; up_ren = 1'b1;
    dn_rdata = 32'hCAFEF00D;
    cyc(2);
    @(negedge CLK);
    chk("s3_hold", up_busy, 1'b1);
    chk("s3_noren", dn_ren, 1'b0);
    @(posedge CLK); #1;
    dn_busy = 1'b0;
    cyc(1);
    dn_busy = 1'b1;
    cyc(1);
    @(negedge CLK);
    chk("s3_ren", dn_ren, 1'b1);
    chk("s3_raddr", dn_addr, 32'h200);
    chk("s3_rwen", dn_wen, 1'b0);
    cyc(3);
    dn_busy = 1'b0;
    @(negedge CLK);
    chk("s3_done", up_busy, 1'b0);
    chk("s3_rdata", up_rdata, 32'hCAFEF00D);
    @(posedge CLK); #1;
    up_ren = 1'b0; dn_busy = 1'b1;
    cyc(1);
    chk("s3_rdata0", up_rdata, 32'h0);
    chk("s3_ren0", dn_ren, 1'b0);

    // read and write together act as a read only
    up_addr = 32'h300; up_wdata = 32'h77; up_ren = 1'b1; up_wen = 1'b1;
    dn_busy = 1'b0; dn_rdata = 32'h55;
    cyc(1);
    @(negedge CLK);
    chk("s3b_done", up_busy, 1'b0);
    chk("s3b_rdata", up_rdata, 32'h55);
    @(posedge CLK); #1;
    up_ren = 1'b0; up_wen = 1'b0; dn_busy = 1'b1;
    cyc(1);
    chk("s3b_empty", empty, 1'b1);

    // steady push+pop at occupancy 2 with pointer wrap
    log_a.delete(); log_d.delete();
    for (int i = 0; i < 14; i++) begin
      if (i == 2) dn_busy = 1'b0;
      wr(32'h1000 + 32'(i * 4), 32'hB000 + 32'(i), 4'h5, w);
      chk("s4_lat", w, 0);
    end
    chk("s4_nonempty", empty, 1'b0);
    drain();
    chk("s4_cnt", log_a.size(), 14);
    for (int i = 0; i < 14 && i < log_a.size(); i++) begin
      chk("s4_addr", log_a[i], 32'h1000 + 32'(i * 4));
      chk("s4_data", log_d[i], 32'hB000 + 32'(i));
    end

    // flush blocks new writes until drained and released
    for (int i = 0; i < 3; i++)
      wr(32'h400 + 32'(i * 4), 32'hC000 + 32'(i), 4'hF, w);
    up_addr = 32'h500; up_wdata = 32'hD00D; up_wen = 1'b1; flush = 1'b1;
    cyc(1);
    @(negedge CLK);
    chk("s5_hold", up_busy, 1'b1);
    @(posedge CLK); #1;
    dn_busy = 1'b0;
    k = 0;
    @(negedge CLK);
    while (empty !== 1'b1 && k < 20) begin
      k++;
      @(negedge CLK);
    end
    chk("s5_empty", empty, 1'b1);
    chk("s5_pops", k, 3);
    chk("s5_still", up_busy, 1'b1);
    @(posedge CLK); #1;
    flush = 1'b0;
    @(negedge CLK);
    chk("s5_accept", up_busy, 1'b0);
    @(posedge CLK); #1;
    up_wen = 1'b0;
    drain();

    // asynchronous reset in the middle of a drain
    wr(32'h600, 32'hE000, 4'hF, w);
    wr(32'h604, 32'hE001, 4'hF, w);
    chk("s6_wen", dn_wen, 1'b1);
    #2 nRST = 1'b0;
    #1;
    chk("s6_wen0", dn_wen, 1'b0);
    chk("s6_addr0", dn_addr, 32'h0);
    chk("s6_busy", up_busy, 1'b1);
    chk("s6_empty", empty, 1'b1);
    cyc(2);
    nRST = 1'b1;
    cyc(1);
    chk("s6_after", empty, 1'b1);
    chk("s6_nowen", dn_wen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
